hdmi_text_axi_regs: RTL
=======================

// Module: hdmi_text_axi_regs
// PURPOSE
//  AXI4-Lite responder (slave) for the HDMI text controller: it terminates the
//  bus transactions that MicroBlaze issues. Backs 600 VRAM words plus 1 control
//  word (index 600) with byte-strobe writes and AXI readback. Exports a
//  registered pixel-side read port and the control word to the draw logic.
//  Sits between the AXI interconnect and the text-mode renderer.
// PARAMETERS
//  C_AXI_DATA_WIDTH  32   bus data width; only 32 supported
//  C_AXI_ADDR_WIDTH  16   byte address width; word index = addr[ADDR_W-1:2]
//  NUM_REGS          601  words implemented (600 VRAM + control)
// PORTS
//  axi_aclk      in   1   single clock for bus and register file
//  axi_aresetn   in   1   asynchronous, active-low reset
//  axi_awaddr    in   AW  write byte address
//  axi_awprot    in   3   ignored
//  axi_awvalid   in   1   write address valid
//  axi_awready   out  1   write address accepted
//  axi_wdata     in   32  write data
//  axi_wstrb     in   4   byte enables; bit n enables wdata[8n+7:8n]
//  axi_wvalid    in   1   write data valid
//  axi_wready    out  1   write data accepted
//  axi_bresp     out  2   00 OKAY, 10 SLVERR (index >= NUM_REGS)
//  axi_bvalid    out  1   write response valid
//  axi_bready    in   1   master ready for response
//  axi_araddr    in   AW  read byte address
//  axi_arprot    in   3   ignored
//  axi_arvalid   in   1   read address valid
//  axi_arready   out  1   read address accepted
//  axi_rdata     out  32  read data
//  axi_rresp     out  2   00 OKAY, 10 SLVERR
//  axi_rvalid    out  1   read data valid
//  axi_rready    in   1   master ready for read data
//  vram_idx      in   10  pixel-side word index (0..599)
//  vram_word     out  32  pixel-side data, 1-cycle latency
//  ctrl_word     out  32  control register (index 600), direct from flop
// BEHAVIOUR
//  Reset: all outputs 0; every register cleared to 0; AW/W holding latches empty.
//  Write channel:
//  - AW and W are accepted independently, in either order or together.
//  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
//  - A channel's handshake (valid && ready) latches its addr or data+strb.
//  - Commit edge: first edge where both are held (or handshake that cycle).
//    At it: word[idx] <= per-byte merge under strb; latches clear; bvalid <= 1.
//  - bvalid stays high, bresp stable, until bready; both clear on that edge.
//  - No new AW/W is accepted while bvalid is high. Minimum write: 2 cycles.
//  - idx >= NUM_REGS: no register changes; bresp = 10. strb = 0: no change, OKAY.
//  Read channel:
//  - arready = !rvalid. On AR handshake, rdata/rresp are captured from the
//    current array; rvalid <= 1 next edge. Latency 1 cycle.
//  - rvalid and rdata are held until rready; they clear on that edge.
//  - Out of range: rdata = 0, rresp = 10.
//  Same-edge read and write to one index: read returns the pre-write value.
//  Pixel port: vram_word <= word[vram_idx] every edge; vram_idx > 599 gives 0.
//  ctrl_word reflects a committed control write on the cycle after commit.
//  Reset asserted mid-transaction: immediate return to reset state; transaction lost.
// STRUCTURE
//  hdmi_text_pkg: NUM_VRAM=600, CTRL_IDX=600, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
//  Sub-module hdmi_text_regfile: word array, strobe-merge write port,
//  AXI read port, and registered pixel read port. Control word is a tap of
//  this array. This top holds the AW/W/B/AR/R channel control only.
// TESTING
//  1 Reset, then write 0x001F6000 to byte addr 2400 -> bresp=00; ctrl_word=0x001F6000.
//  2 Write 0xAABBCCDD to addr 0 with strb=F, then 0x11223344 with strb=0101
//    -> readback 0xAA22CC44.
//  3 AW 3 cycles before W, then W 3 cycles before AW -> one commit each.
//    bvalid held 5 cycles with bready low.
//  4 Write word[i]=i for i=0..599, read each back -> exact match.
//    vram_idx=37 -> vram_word=37 one cycle later.
//  5 Read addr 2404 -> rresp=10, rdata=0. Write addr 4000 -> bresp=10, no register changed.
//  6 rready low for 4 cycles -> rdata stable, arready=0.
//    Deassert aresetn mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/hdmi_text_pkg.sv
// Shared constants and the register-file write request for the HDMI text AXI register block.
package hdmi_text_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned NUM_VRAM   = 600;
  localparam int unsigned CTRL_IDX   = 600;
  localparam int unsigned MEM_IDX_W  = 10;
  localparam int unsigned VRAM_IDX_W = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One committed bus write; en is only set for in-range indices
  typedef struct packed {
    logic                 en;
    logic [MEM_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
    logic [STRB_W-1:0]    strb;
  } reg_wr_t;

endpackage

// File: rtl/hdmi_text_regfile.sv
// Word array behind the AXI registers: strobe-merge write, combinational bus read,
// registered pixel read and a direct tap of the control word.
module hdmi_text_regfile
  import hdmi_text_pkg::*;
#(
  parameter int unsigned NUM_REGS = 601
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  reg_wr_t               wr_i,
  input  logic [MEM_IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0]     rd_data_c_o,
  input  logic [VRAM_IDX_W-1:0] vram_idx_i,
  output logic [DATA_W-1:0]     vram_word_o,
  output logic [DATA_W-1:0]     ctrl_word_o
);

  localparam logic [VRAM_IDX_W-1:0] VRAM_LIMIT = VRAM_IDX_W'(NUM_VRAM);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] vram_word_q;

  // Pixel read and bus read both see the array as it stood before this edge's write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[MEM_IDX_W'(i)] <= '0;
      end
      vram_word_q <= '0;
    end else begin
      if (wr_i.en) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wr_i.strb[b]) begin
            mem_q[wr_i.idx][8*b +: 8] <= wr_i.data[8*b +: 8];
          end
        end
      end
      vram_word_q <= (vram_idx_i < VRAM_LIMIT) ? mem_q[vram_idx_i] : '0;
    end
  end

  assign rd_data_c_o = mem_q[rd_idx_i];
  assign vram_word_o = vram_word_q;
  assign ctrl_word_o = mem_q[MEM_IDX_W'(CTRL_IDX)];

endmodule

// File: rtl/hdmi_text_axi_regs.sv
// AXI4-Lite responder for the HDMI text controller: AW/W/B/AR/R channel control
// in front of the VRAM + control register file.
module hdmi_text_axi_regs
  import hdmi_text_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 16,
  parameter int unsigned NUM_REGS         = 601
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  input  logic [VRAM_IDX_W-1:0]         vram_idx,
  output logic [DATA_W-1:0]             vram_word,
  output logic [DATA_W-1:0]             ctrl_word
);

  localparam int unsigned IDX_W = C_AXI_ADDR_WIDTH - 2;
  localparam int unsigned BS_W  = C_AXI_DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_REGS);

  logic                        aw_held_q, aw_held_d;
  logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
  logic                        w_held_q, w_held_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BS_W-1:0]             wstrb_q, wstrb_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        rvalid_q, rvalid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        arready_q, arready_d;

  logic                        aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [IDX_W-1:0]            aw_idx_c, ar_idx_c, wr_idx_c;
  logic [C_AXI_DATA_WIDTH-1:0] wr_data_c;
  logic [BS_W-1:0]             wr_strb_c;
  logic                        wr_ok_c, ar_ok_c;
  logic [DATA_W-1:0]           rd_data_c;
  reg_wr_t                     wr_req_c;
  logic                        unused_c;

  assign aw_idx_c = axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
  assign ar_idx_c = axi_araddr[C_AXI_ADDR_WIDTH-1:2];
  assign unused_c = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  assign aw_hs_c = axi_awvalid & awready_q;
  assign w_hs_c  = axi_wvalid & wready_q;
  assign ar_hs_c = axi_arvalid & arready_q;

  // A write commits on the first edge where both halves are held or arriving
  assign commit_c  = (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);
  assign wr_idx_c  = aw_held_q ? aw_idx_q : aw_idx_c;
  assign wr_data_c = w_held_q ? wdata_q : axi_wdata;
  assign wr_strb_c = w_held_q ? wstrb_q : axi_wstrb;
  assign wr_ok_c   = wr_idx_c < IDX_LIMIT;
  assign ar_ok_c   = ar_idx_c < IDX_LIMIT;

  assign wr_req_c.en   = commit_c & wr_ok_c;
  assign wr_req_c.idx  = MEM_IDX_W'(wr_idx_c);
  assign wr_req_c.data = wr_data_c;
  assign wr_req_c.strb = wr_strb_c;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (bvalid_q && axi_bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
    // Ready is low while bvalid is high, so a commit never overlaps a pending response
    if (commit_c) begin
      aw_held_d = 1'b0;
      aw_idx_d  = '0;
      w_held_d  = 1'b0;
      wdata_d   = '0;
      wstrb_d   = '0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs_c) begin
        aw_held_d = 1'b1;
        aw_idx_d  = aw_idx_c;
      end
      if (w_hs_c) begin
        w_held_d = 1'b1;
        wdata_d  = axi_wdata;
        wstrb_d  = axi_wstrb;
      end
    end

    if (rvalid_q && axi_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
    end
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok_c ? rd_data_c : '0;
      rresp_d  = ar_ok_c ? RESP_OKAY : RESP_SLVERR;
    end

    // Readies are registered copies of the next-state acceptance rules
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
    end
  end

  hdmi_text_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .wr_i        (wr_req_c),
    .rd_idx_i    (MEM_IDX_W'(ar_idx_c)),
    .rd_data_c_o (rd_data_c),
    .vram_idx_i  (vram_idx),
    .vram_word_o (vram_word),
    .ctrl_word_o (ctrl_word)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;

endmodule
